// File: rtl/seg7_scan_if.sv
// Multiplexed seven-segment bus plus the recovered-digit results observed on it.
interface seg7_scan_if #(
    parameter int NDIG = 4
);
    logic [NDIG-1:0]   an;
    logic [1:7]        seg;
    logic [4*NDIG-1:0] hex_out;
    logic [NDIG-1:0]   digit_valid;
    logic [NDIG-1:0]   blank;
    logic [NDIG-1:0]   pat_err;
    logic              frame_done;
    logic              stale;

    modport master (
        output an, seg,
        input  hex_out, digit_valid, blank, pat_err, frame_done, stale
    );
    modport slave (
        input  an, seg,
        output hex_out, digit_valid, blank, pat_err, frame_done, stale
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a scanned seven-segment bus once each pattern holds
// stable; flags blank/invalid patterns, completed frames and a stalled scan.
module seg7_scan_decoder #(
    parameter int NDIG       = 4,
    parameter int STABLE_CNT = 4,
    parameter int TIMEOUT    = 1000000
) (
    input logic       clk,
    input logic       rst_n,
    seg7_scan_if.slave bus
);
    localparam int IW = NDIG + 7;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [IW-1:0]          in_q, samp;
    logic [7:0]             cnt_q, cnt_d;
    logic                   cap_q, cap_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   stale_q, stale_d;
    logic                   frame_q, frame_d;
    logic [NDIG-1:0][3:0]   hex_q, hex_d;
    logic [NDIG-1:0]        valid_q, valid_d, blank_q, blank_d, perr_q, perr_d;
    logic [NDIG-1:0]        seen_q, seen_d, cap_an;
    logic [6:0]             cap_pat;
    logic [4:0]             dec;

    // Returns {hit, value}; pattern bit 6 is segment a.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1111110: decode = 5'h10;
            7'b0110000: decode = 5'h11;
            7'b1101101: decode = 5'h12;
            7'b1111001: decode = 5'h13;
            7'b0110011: decode = 5'h14;
            7'b1011011: decode = 5'h15;
            7'b1011111: decode = 5'h16;
            7'b1110000: decode = 5'h17;
            7'b1111111: decode = 5'h18;
            7'b1111011: decode = 5'h19;
            7'b1110111: decode = 5'h1A;
            7'b0011111: decode = 5'h1B;
            7'b1001110: decode = 5'h1C;
            7'b0111101: decode = 5'h1D;
            7'b1001111: decode = 5'h1E;
            7'b1000111: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    // in_q still holds the captured sample on the cycle after the capture edge.
    assign cap_an  = in_q[IW-1:7];
    assign cap_pat = in_q[6:0];
    assign dec     = decode(cap_pat);

    always_comb begin
        samp  = {bus.an, bus.seg};
        cnt_d = cnt_q;
        cap_d = 1'b0;
        if (!$onehot(bus.an) || samp != in_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != 8'(STABLE_CNT)) cnt_d = cnt_q + 8'd1;
            cap_d = (cnt_q == 8'(STABLE_CNT - 2));
        end

        tmo_d   = tmo_q;
        stale_d = stale_q;
        if (cap_d) begin
            tmo_d   = '0;
            stale_d = 1'b0;
        end else begin
            if (tmo_q != TW'(TIMEOUT)) tmo_d = tmo_q + 1'b1;
            if (tmo_d == TW'(TIMEOUT)) stale_d = 1'b1;
        end
    end

    always_comb begin
        hex_d   = hex_q;
        valid_d = valid_q;
        blank_d = blank_q;
        perr_d  = perr_q;
        if (tmo_d == TW'(TIMEOUT)) valid_d = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cap_q && cap_an[i]) begin
                if (dec[4]) begin
                    hex_d[i]   = dec[3:0];
                    valid_d[i] = 1'b1;
                    blank_d[i] = 1'b0;
                    perr_d[i]  = 1'b0;
                end else begin
                    valid_d[i] = 1'b0;
                    blank_d[i] = (cap_pat == 7'b0000000);
                    perr_d[i]  = (cap_pat != 7'b0000000);
                end
            end
        end
        frame_d = &seen_q;
        seen_d  = (frame_d ? '0 : seen_q) | (cap_q ? cap_an : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q    <= '0;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
            tmo_q   <= '0;
            stale_q <= 1'b0;
            frame_q <= 1'b0;
            hex_q   <= '0;
            valid_q <= '0;
            blank_q <= '0;
            perr_q  <= '0;
            seen_q  <= '0;
        end else begin
            in_q    <= samp;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            tmo_q   <= tmo_d;
            stale_q <= stale_d;
            frame_q <= frame_d;
            hex_q   <= hex_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            perr_q  <= perr_d;
            seen_q  <= seen_d;
        end
    end

    assign bus.hex_out     = hex_q;
    assign bus.digit_valid = valid_q;
    assign bus.blank       = blank_q;
    assign bus.pat_err     = perr_q;
    assign bus.frame_done  = frame_q;
    assign bus.stale       = stale_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed scan sequences against a cycle-accurate scoreboard of expected captures.
module tb_seg7_scan_decoder;
    localparam int NDIG = 4;
    localparam int SC   = 4;
    localparam int TMO  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_if #(.NDIG(NDIG)) bus ();

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CNT(SC), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         due;
        int         dig;
        logic [6:0] pat;
    } cap_t;

    cap_t sbq[$];

    logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    int checks = 0, errors = 0;
    int cyc = 0, last_cap = 0, frame_due = -1, frames = 0;
    logic [15:0] exp_hex   = '0;
    logic [3:0]  exp_valid = '0, exp_blank = '0, exp_perr = '0, seen = '0;
    logic        exp_stale, exp_frame;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Applies expected captures at the cycle they become visible and compares every cycle.
    always @(negedge clk) begin
        if (!rst_n) last_cap = cyc;
        if (sbq.size() > 0 && sbq[0].due - 1 == cyc) last_cap = cyc;
        exp_stale = rst_n && (cyc - last_cap >= TMO);
        if (exp_stale) exp_valid = '0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            cap_t it;
            int   hit;
            it  = sbq.pop_front();
            hit = -1;
            for (int v = 0; v < 16; v++) if (tbl[v] == it.pat) hit = v;
            if (hit >= 0) begin
                exp_hex[4*it.dig +: 4] = 4'(hit);
                exp_valid[it.dig] = 1'b1;
                exp_blank[it.dig] = 1'b0;
                exp_perr[it.dig]  = 1'b0;
            end else begin
                exp_valid[it.dig] = 1'b0;
                exp_blank[it.dig] = (it.pat == 7'b0);
                exp_perr[it.dig]  = (it.pat != 7'b0);
            end
            seen[it.dig] = 1'b1;
            if (&seen) frame_due = cyc + 1;
        end
        exp_frame = (cyc == frame_due);
        if (exp_frame) seen = '0;
        if (bus.frame_done) frames++;
        chk("hex_out",     32'(bus.hex_out),     32'(exp_hex));
        chk("digit_valid", 32'(bus.digit_valid), 32'(exp_valid));
        chk("blank",       32'(bus.blank),       32'(exp_blank));
        chk("pat_err",     32'(bus.pat_err),     32'(exp_perr));
        chk("frame_done",  32'(bus.frame_done),  32'(exp_frame));
        chk("stale",       32'(bus.stale),       32'(exp_stale));
    end

    // Drives one bus pattern for `hold` samples; queues a capture if it must be accepted.
    task automatic show(input logic [3:0] a, input logic [6:0] p, input int hold);
        int d;
        bus.an  = a;
        bus.seg = p;
        if ($onehot(a) && hold >= SC) begin
            d = 0;
            for (int i = 0; i < NDIG; i++) if (a[i]) d = i;
            sbq.push_back('{cyc + 1 + SC, d, p});
        end
        repeat (hold) @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".hex"},   32'(bus.hex_out),     32'h0);
        chk({tag, ".valid"}, 32'(bus.digit_valid), 32'h0);
        chk({tag, ".blank"}, 32'(bus.blank),       32'h0);
        chk({tag, ".perr"},  32'(bus.pat_err),     32'h0);
        chk({tag, ".frame"}, 32'(bus.frame_done),  32'h0);
        chk({tag, ".stale"}, 32'(bus.stale),       32'h0);
    endtask

    initial begin
        bus.an  = '0;
        bus.seg = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Full scan 1,2,3,4 on digits 0..3
        show(4'b0001, tbl[1], 8);
        show(4'b0010, tbl[2], 8);
        show(4'b0100, tbl[3], 8);
        show(4'b1000, tbl[4], 8);
        show(4'b0000, 7'b0, 4);
        chk("scan.hex",    32'(bus.hex_out),     32'h4321);
        chk("scan.valid",  32'(bus.digit_valid), 32'hF);
        chk("scan.frames", 32'(frames),          32'd1);

        // Short glitch inside an E window is never captured
        show(4'b0100, 7'b1001111, 2);
        show(4'b0100, 7'b0110000, 3);
        show(4'b0100, 7'b1001111, 8);
        chk("glitch.hex2", 32'(bus.hex_out[11:8]), 32'hE);

        // Blank then invalid on digit 1
        show(4'b0010, 7'b0000000, 8);
        chk("blank1", 32'(bus.blank[1]), 32'h1);
        show(4'b0010, 7'b1010101, 8);
        chk("perr1",   32'(bus.pat_err[1]),     32'h1);
        chk("valid1",  32'(bus.digit_valid[1]), 32'h0);
        chk("hex1",    32'(bus.hex_out[7:4]),   32'h2);

        // Overlap and blanking intervals between digits, then finish the frame
        show(4'b0011, tbl[5], 10);
        show(4'b0000, tbl[5], 10);
        chk("overlap.frames", 32'(frames), 32'd1);
        show(4'b0001, tbl[7], 8);
        show(4'b1000, tbl[9], 8);
        show(4'b0000, 7'b0, 4);
        chk("frame2.frames", 32'(frames), 32'd2);

        // Stall the scan until stale, then resume
        show(4'b0000, 7'b0, 80);
        chk("stale.set",   32'(bus.stale),       32'h1);
        chk("stale.valid", 32'(bus.digit_valid), 32'h0);
        show(4'b0001, 7'b1000111, 8);
        chk("resume.stale", 32'(bus.stale),        32'h0);
        chk("resume.hex0",  32'(bus.hex_out[3:0]), 32'hF);
        chk("resume.valid", 32'(bus.digit_valid),  32'h1);

        // Reset mid-window and mid-frame
        show(4'b0010, tbl[6], 2);
        rst_n = 1'b0;
        sbq.delete();
        exp_hex = '0; exp_valid = '0; exp_blank = '0; exp_perr = '0;
        seen = '0; frame_due = -1;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        show(4'b0001, tbl[10], 8);
        show(4'b0010, tbl[11], 8);
        show(4'b0100, tbl[12], 8);
        show(4'b0000, 7'b0, 6);
        chk("postreset.noframe", 32'(frames), 32'd2);
        show(4'b1000, tbl[13], 8);
        show(4'b0000, 7'b0, 4);
        chk("postreset.hex",    32'(bus.hex_out),     32'hDCBA);
        chk("postreset.valid",  32'(bus.digit_valid), 32'hF);
        chk("postreset.frames", 32'(frames),          32'd3);
        chk("scoreboard.empty", 32'(sbq.size()),      32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
